// File: rtl/ifetch_redirect.sv
// Fetch front end: PC register, redirect handling, <=2 outstanding SRAM-like requests, 2-entry {pc,inst} buffer to decode.
// Response -> fs_valid next cycle; requests are credit-limited so the output buffer never overflows when decode stalls.

// Small synchronous FIFO with flush; DEPTH must be a power of two, and the caller never pushes when full or pops when empty.
module ifetch_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_rdy,
   output logic [W-1:0]           head_dat,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_rdy) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push_vld) - (AW+1)'(pop_rdy);
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module ifetch_redirect #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        de_allowin,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_t;

   logic [31:0] pc;
   logic [31:0] br_pc;
   logic [31:0] rsp_pc;
   logic [1:0]  pend;
   logic [1:0]  disc;
   logic [1:0]  ocnt;
   logic [2:0]  occ;
   logic        acc;
   logic        pop;
   logic        obuf_push;
   fetch_t      obuf_in;
   fetch_t      obuf_head;

   assign br_pc = br_target & 32'hffff_fffc;

   // Credit: every outstanding request may still land in obuf, so count them as occupied.
   assign occ       = 3'(pend) + 3'(ocnt) - 3'(pop);
   assign inst_req  = !reset && !br_valid && (occ < 3'd2);
   assign inst_addr = pc;
   assign acc       = inst_req && inst_addr_ok;

   assign fs_valid  = (ocnt != 2'd0) && !br_valid;
   assign pop       = fs_valid && de_allowin;
   assign obuf_push = inst_data_ok && (disc == 2'd0) && !br_valid;
   assign obuf_in   = '{pc: rsp_pc, inst: inst_rdata};
   assign fs_pc     = obuf_head.pc;
   assign fs_inst   = obuf_head.inst;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (br_valid) begin
         pc <= br_pc;
      end else if (acc) begin
         pc <= pc + 32'd4;
      end
   end

   // Responses are in order, so the oldest 'disc' of the outstanding ones belong to the squashed path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disc <= 2'd0;
      end else if (br_valid) begin
         disc <= pend - 2'(inst_data_ok);
      end else if (inst_data_ok && (disc != 2'd0)) begin
         disc <= disc - 2'd1;
      end
   end

   // The pending-PC queue occupancy is the outstanding request count.
   ifetch_fifo #(.W(32), .DEPTH(2)) u_pcq (
      .clk      (clk),
      .reset    (reset),
      .flush    (1'b0),
      .push_vld (acc),
      .push_dat (pc),
      .pop_rdy  (inst_data_ok),
      .head_dat (rsp_pc),
      .count    (pend)
   );

   ifetch_fifo #(.W($bits(fetch_t)), .DEPTH(2)) u_obuf (
      .clk      (clk),
      .reset    (reset),
      .flush    (br_valid),
      .push_vld (obuf_push),
      .push_dat (obuf_in),
      .pop_rdy  (pop),
      .head_dat (obuf_head),
      .count    (ocnt)
   );
endmodule

// File: tb/tb_ifetch_redirect.sv
// Bench for ifetch_redirect: in-order latency-programmable memory model plus an expected-PC scoreboard checked on every decode pop.
module tb_ifetch_redirect;
   localparam logic [31:0] RST_PC = 32'h1c000000;

   logic        clk;
   logic        reset;
   logic        br_valid;
   logic [31:0] br_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        de_allowin;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;

   ifetch_redirect dut (
      .clk          (clk),
      .reset        (reset),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .de_allowin   (de_allowin),
      .fs_valid     (fs_valid),
      .fs_pc        (fs_pc),
      .fs_inst      (fs_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_acc    = 0;
   int          n_pop    = 0;
   int          req_limit = 0;
   int          mem_lat  = 1;
   bit          mem_hold = 1'b0;
   bit          addr_ok_en = 1'b0;
   logic        s_req;
   logic        s_fvld;
   logic [31:0] s_addr;
   logic [31:0] exp_q [$];
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   int          pop_cyc [$];

   function automatic logic [31:0] img(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // One clock: drive memory-side inputs, sample at negedge, score pops, log accepts.
   task automatic step();
      logic [31:0] e;
      inst_addr_ok = addr_ok_en && (n_acc < req_limit);
      if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         inst_data_ok = 1'b1;
         inst_rdata   = img(mq_addr[0]);
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         inst_data_ok = 1'b0;
         inst_rdata   = 32'h0;
      end
      @(negedge clk);
      s_req  = inst_req;
      s_addr = inst_addr;
      s_fvld = fs_valid;
      if (fs_valid && de_allowin) begin
         pop_cyc.push_back(cyc);
         n_pop++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got pc=%h inst=%h, expected no output", fs_pc, fs_inst);
         end else begin
            e = exp_q.pop_front();
            if (fs_pc !== e || fs_inst !== img(e)) begin
               n_fail++;
               $display("FAIL sb_entry: got pc=%h inst=%h, expected pc=%h inst=%h", fs_pc, fs_inst, e, img(e));
            end
         end
      end
      if (inst_req && inst_addr_ok) begin
         mq_addr.push_back(inst_addr);
         mq_due.push_back(cyc + mem_lat);
         n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (exp_q.size() > 0 || mq_addr.size() > 0 || n_acc < req_limit); i++) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (s_req !== 1'b0 || s_fvld !== 1'b0 || s_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b fs_valid=%b addr=%h, expected 0 0 %h", s_req, s_fvld, s_addr, RST_PC);
         end
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== RST_PC || s_fvld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_req: got req=%b addr=%h fs_valid=%b, expected 1 %h 0", s_req, s_addr, s_fvld, RST_PC);
      end
   endtask

   task automatic test_straight();
      int start;
      mem_lat = 1; de_allowin = 1'b1; addr_ok_en = 1'b1;
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(RST_PC + 32'(4 * i));
      start = cyc;
      req_limit = n_acc + 8;
      drain();
      n_checks++;
      if (exp_q.size() != 0 || pop_cyc.size() != 8) begin
         n_fail++;
         $display("FAIL straight_count: got %0d outputs with %0d left, expected 8 and 0", pop_cyc.size(), exp_q.size());
      end else begin
         n_checks++;
         if (pop_cyc[0] != start + 2 || pop_cyc[7] != start + 9) begin
            n_fail++;
            $display("FAIL straight_timing: got first/last cycle %0d/%0d, expected %0d/%0d", pop_cyc[0], pop_cyc[7], start + 2, start + 9);
         end
      end
   endtask

   task automatic test_backpressure();
      int acc0, pop0;
      mem_lat = 1; de_allowin = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back(32'h1c000020 + 32'(4 * i));
      acc0 = n_acc; pop0 = n_pop;
      req_limit = n_acc + 6;
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if (n_acc - acc0 != 2 || s_req !== 1'b0 || s_fvld !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stall: got accepts=%0d req=%b fs_valid=%b, expected 2 0 1", n_acc - acc0, s_req, s_fvld);
      end
      de_allowin = 1'b1;
      drain();
      n_checks++;
      if (exp_q.size() != 0 || n_pop - pop0 != 6) begin
         n_fail++;
         $display("FAIL bp_drain: got %0d outputs with %0d left, expected 6 and 0", n_pop - pop0, exp_q.size());
      end
   endtask

   task automatic test_redirect_stale();
      mem_lat = 2; de_allowin = 1'b1;
      req_limit = n_acc + 2;
      step();
      step();
      br_valid = 1'b1; br_target = 32'h1c000100; mem_hold = 1'b1;
      step();
      n_checks++;
      if (s_req !== 1'b0 || s_fvld !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_redirect_cycle: got req=%b fs_valid=%b, expected 0 0", s_req, s_fvld);
      end
      br_valid = 1'b0; mem_hold = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h1c000100 + 32'(4 * i));
      req_limit = n_acc + 4;
      drain();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stale_drain: got %0d entries left, expected 0", exp_q.size());
      end
   endtask

   task automatic test_redirect_coincide();
      mem_lat = 1; de_allowin = 1'b1;
      req_limit = n_acc + 1;
      step();
      br_valid = 1'b1; br_target = 32'h1c000200;
      step();
      n_checks++;
      if (s_req !== 1'b0) begin
         n_fail++;
         $display("FAIL coincide_req: got req=%b, expected 0", s_req);
      end
      br_valid = 1'b0;
      exp_q.push_back(32'h1c000200);
      exp_q.push_back(32'h1c000204);
      req_limit = n_acc + 2;
      step();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h1c000200 || s_fvld !== 1'b0) begin
         n_fail++;
         $display("FAIL coincide_next: got req=%b addr=%h fs_valid=%b, expected 1 1c000200 0", s_req, s_addr, s_fvld);
      end
      drain();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL coincide_drain: got %0d entries left, expected 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      mem_lat = 2; de_allowin = 1'b1;
      req_limit = n_acc + 1;
      step();
      br_valid = 1'b1; br_target = 32'h1c000300;
      step();
      br_target = 32'h1c000400;
      step();
      br_valid = 1'b0;
      exp_q.push_back(32'h1c000400);
      exp_q.push_back(32'h1c000404);
      req_limit = n_acc + 2;
      step();
      n_checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h1c000400) begin
         n_fail++;
         $display("FAIL b2b_next: got req=%b addr=%h, expected 1 1c000400", s_req, s_addr);
      end
      drain();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got %0d entries left, expected 0", exp_q.size());
      end
   endtask

   task automatic test_misaligned_wrap();
      mem_lat = 1; de_allowin = 1'b1;
      br_valid = 1'b1; br_target = 32'h1c000102;
      step();
      br_valid = 1'b0;
      exp_q.push_back(32'h1c000100);
      req_limit = n_acc + 1;
      step();
      n_checks++;
      if (s_addr !== 32'h1c000100 || s_req !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned_addr: got req=%b addr=%h, expected 1 1c000100", s_req, s_addr);
      end
      drain();
      br_valid = 1'b1; br_target = 32'hfffffffc;
      step();
      br_valid = 1'b0;
      exp_q.push_back(32'hfffffffc);
      exp_q.push_back(32'h00000000);
      req_limit = n_acc + 2;
      step();
      step();
      n_checks++;
      if (s_addr !== 32'h00000000) begin
         n_fail++;
         $display("FAIL wrap_addr: got addr=%h, expected 00000000", s_addr);
      end
      drain();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_drain: got %0d entries left, expected 0", exp_q.size());
      end
   endtask

   initial begin
      reset        = 1'b1;
      br_valid     = 1'b0;
      br_target    = 32'h0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
      de_allowin   = 1'b0;
      test_reset();
      test_straight();
      test_backpressure();
      test_redirect_stale();
      test_redirect_coincide();
      test_back_to_back();
      test_misaligned_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
